// File: rtl/vchip_op_sequencer.sv
// -----------------------------------------------------------------------------
// vchip_op_sequencer
//
// Drives a small ALU chip over its register bus. The block wakes and configures
// the chip after reset, then runs each accepted request as a fixed sequence:
// write left operand, write right operand, write command, idle for WAIT_CYC
// cycles, then read the result back. If the chip raises its error interrupt,
// the sequencer pulses the chip recovery input and clears the interrupt. If the
// chip raises its export interrupt, the block locks. In the locked state every
// later request is answered at once, without bus traffic, with rsp_exp=1.
//
// Ports
//   clk, rst_b                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake; req_op/left/right payload
//   rsp_valid/rsp_ready        response handshake; rsp_data/err/exp payload
//   chip_select, address,      chip register bus (rw_: 1=read, 0=write),
//   byte_en, rw_, wdata, rdata rdata is combinational in the read cycle
//   interrupt_1, interrupt_2   chip error / export interrupts
//   maroon, gold               chip state-machine control inputs
// -----------------------------------------------------------------------------
module vchip_op_sequencer #(
    parameter int unsigned WAIT_CYC = 1  // legal 1..7
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_left,
    input  logic [15:0] req_right,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        rsp_exp,
    output logic        chip_select,
    output logic [6:0]  address,
    output logic [1:0]  byte_en,
    output logic        rw_,
    output logic [15:0] wdata,
    input  logic [15:0] rdata,
    input  logic        interrupt_1,
    input  logic        interrupt_2,
    output logic        maroon,
    output logic        gold
);

    typedef enum logic [3:0] {
        INIT_WAKE,
        INIT_CFG,
        IDLE,
        WR_LEFT,
        WR_RIGHT,
        WR_CMD,
        WAIT,
        READ,
        RECOVER,
        CLR_INT,
        RESP,
        DEAD
    } state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYC - 1);

    localparam logic [6:0] ADDR_INT_CLR = 7'h04;
    localparam logic [6:0] ADDR_CMD     = 7'h08;
    localparam logic [6:0] ADDR_CFG     = 7'h0C;
    localparam logic [6:0] ADDR_LEFT    = 7'h10;
    localparam logic [6:0] ADDR_RIGHT   = 7'h14;
    localparam logic [6:0] ADDR_RESULT  = 7'h18;

    state_t      state_q, state_d;
    // armed_q keeps INIT_WAKE silent while reset is held, so the wake pulse
    // shows up in the first full cycle after release rather than during reset.
    logic        armed_q;
    logic        dead_q, dead_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] left_q, left_d;
    logic [15:0] right_q, right_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_exp_q, rsp_exp_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= INIT_WAKE;
            armed_q    <= 1'b0;
            dead_q     <= 1'b0;
            op_q       <= '0;
            left_q     <= '0;
            right_q    <= '0;
            wait_cnt_q <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            rsp_exp_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= 1'b1;
            dead_q     <= dead_d;
            op_q       <= op_d;
            left_q     <= left_d;
            right_q    <= right_d;
            wait_cnt_q <= wait_cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            rsp_exp_q  <= rsp_exp_d;
        end
    end

    // NOTE: every output of this block is given a default before the case
    // statement, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        dead_d      = dead_q;
        op_d        = op_q;
        left_d      = left_q;
        right_d     = right_q;
        wait_cnt_d  = wait_cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_exp_d   = rsp_exp_q;

        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        chip_select = 1'b0;
        rw_         = 1'b1;
        address     = '0;
        byte_en     = '0;
        wdata       = '0;
        maroon      = 1'b0;
        gold        = 1'b0;

        unique case (state_q)
            INIT_WAKE: begin
                if (armed_q) begin
                    gold    = 1'b1;
                    state_d = INIT_CFG;
                end
            end

            INIT_CFG: begin
                chip_select = 1'b1;
                rw_         = 1'b0;
                address     = ADDR_CFG;
                byte_en     = 2'b10;
                wdata       = 16'h0300;
                state_d     = IDLE;
            end

            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d    = req_op;
                    left_d  = req_left;
                    right_d = req_right;
                    state_d = WR_LEFT;
                end
            end

            WR_LEFT: begin
                chip_select = 1'b1;
                rw_         = 1'b0;
                address     = ADDR_LEFT;
                byte_en     = 2'b11;
                wdata       = left_q;
                state_d     = WR_RIGHT;
            end

            WR_RIGHT: begin
                chip_select = 1'b1;
                rw_         = 1'b0;
                address     = ADDR_RIGHT;
                byte_en     = 2'b11;
                wdata       = right_q;
                state_d     = WR_CMD;
            end

            WR_CMD: begin
                chip_select = 1'b1;
                rw_         = 1'b0;
                address     = ADDR_CMD;
                byte_en     = 2'b11;
                wdata       = {1'b1, 11'h000, op_q};  // bit 15 = start
                wait_cnt_d  = WAIT_LOAD;
                state_d     = WAIT;
            end

            WAIT: begin
                if (wait_cnt_q == 3'd0) begin
                    state_d = READ;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end

            READ: begin
                chip_select = 1'b1;
                rw_         = 1'b1;
                address     = ADDR_RESULT;
                rsp_data_d  = rdata;
                // Export lock outranks a simultaneous error.
                if (interrupt_2) begin
                    rsp_exp_d = 1'b1;
                    rsp_err_d = 1'b0;
                    dead_d    = 1'b1;
                    state_d   = RESP;
                end else if (interrupt_1) begin
                    rsp_exp_d = 1'b0;
                    rsp_err_d = 1'b1;
                    state_d   = RECOVER;
                end else begin
                    rsp_exp_d = 1'b0;
                    rsp_err_d = 1'b0;
                    state_d   = RESP;
                end
            end

            RECOVER: begin
                maroon  = 1'b1;
                state_d = CLR_INT;
            end

            CLR_INT: begin
                chip_select = 1'b1;
                rw_         = 1'b0;
                address     = ADDR_INT_CLR;
                byte_en     = 2'b10;
                wdata       = 16'h0100;
                state_d     = RESP;
            end

            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = dead_q ? DEAD : IDLE;
                end
            end

            DEAD: begin
                // rsp_valid is never high here, so DEAD is always ready.
                req_ready = 1'b1;
                if (req_valid) begin
                    rsp_data_d = '0;
                    rsp_exp_d  = 1'b1;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end
            end

            default: begin
                state_d = INIT_WAKE;
            end
        endcase
    end

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;
    assign rsp_exp  = rsp_exp_q;

endmodule

// File: tb/tb_vchip_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vchip_op_sequencer
//
// Bench for vchip_op_sequencer. A behavioural chip model answers the bus, a
// monitor logs all chip-select cycles, and a scoreboard queue holds the
// expected response for each request that is driven.
// -----------------------------------------------------------------------------
module tb_vchip_op_sequencer;

    localparam int unsigned WAIT_CYC = 1;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [15:0] req_left = '0;
    logic [15:0] req_right = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        rsp_exp;
    logic        chip_select;
    logic [6:0]  address;
    logic [1:0]  byte_en;
    logic        rw_;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        interrupt_1;
    logic        interrupt_2;
    logic        maroon;
    logic        gold;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vchip_op_sequencer #(.WAIT_CYC(WAIT_CYC)) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_left    (req_left),
        .req_right   (req_right),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .rsp_exp     (rsp_exp),
        .chip_select (chip_select),
        .address     (address),
        .byte_en     (byte_en),
        .rw_         (rw_),
        .wdata       (wdata),
        .rdata       (rdata),
        .interrupt_1 (interrupt_1),
        .interrupt_2 (interrupt_2),
        .maroon      (maroon),
        .gold        (gold)
    );

    // ---------------- chip model ----------------
    logic [15:0] m_left = '0, m_right = '0, m_res = '0;
    logic        m_irq1 = 1'b0, m_irq2 = 1'b0;
    logic        export_disabled = 1'b0;

    always @(posedge clk) begin
        if (chip_select && !rw_) begin
            case (address)
                7'h10: m_left  <= wdata;
                7'h14: m_right <= wdata;
                7'h04: if (wdata == 16'h0100) m_irq1 <= 1'b0;
                7'h08: if (wdata[15]) begin
                    case (wdata[3:0])
                        4'h1: begin
                            m_res <= m_left + m_right;
                            if (m_left[15] == m_right[15] &&
                                16'(m_left + m_right) >> 15 != 16'(m_left[15]))
                                m_irq1 <= 1'b1;
                        end
                        4'h2: begin
                            m_res <= m_left - m_right;
                            if (m_left[15] != m_right[15] &&
                                16'(m_left - m_right) >> 15 != 16'(m_left[15]))
                                m_irq1 <= 1'b1;
                        end
                        4'h3: begin
                            if (export_disabled) begin
                                m_res  <= 16'h0000;
                                m_irq2 <= 1'b1;
                            end else begin
                                m_res <= m_left ^ m_right;
                            end
                        end
                        default: begin
                            m_res  <= 16'h0000;
                            m_irq1 <= 1'b1;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign rdata       = (chip_select && rw_ && address == 7'h18) ? m_res : 16'h0000;
    assign interrupt_1 = m_irq1;
    assign interrupt_2 = m_irq2;

    // ---------------- bus monitor ----------------
    logic [25:0] bus_log[$];
    int          maroon_cnt = 0;

    always @(negedge clk) begin
        if (rst_b && chip_select) bus_log.push_back({rw_, address, wdata, byte_en});
        if (rst_b && maroon && !gold) maroon_cnt++;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [15:0] data;
        logic        err;
        logic        exp;
        int          lat;
    } exp_t;

    exp_t sb[$];
    logic dead_m = 1'b0;

    task automatic push_expected(input logic [3:0] op, input logic [15:0] l,
                                 input logic [15:0] r);
        exp_t        e;
        logic [15:0] s;
        e.err = 1'b0;
        e.exp = 1'b0;
        e.lat = 5 + WAIT_CYC;
        if (dead_m) begin
            e.data = 16'h0000;
            e.exp  = 1'b1;
            e.lat  = 1;
        end else begin
            case (op)
                4'h1: begin
                    s = l + r;
                    e.data = s;
                    e.err  = (l[15] == r[15]) && (s[15] != l[15]);
                end
                4'h2: begin
                    s = l - r;
                    e.data = s;
                    e.err  = (l[15] != r[15]) && (s[15] != l[15]);
                end
                4'h3: begin
                    e.data = export_disabled ? 16'h0000 : (l ^ r);
                    e.exp  = export_disabled;
                end
                default: begin
                    e.data = 16'h0000;
                    e.err  = 1'b1;
                end
            endcase
            if (e.err) e.lat = 7 + WAIT_CYC;
        end
        sb.push_back(e);
    endtask

    // Runs one request end to end; stall = cycles rsp_ready is held low in RESP.
    task automatic do_op(input logic [3:0] op, input logic [15:0] l,
                         input logic [15:0] r, input int stall);
        exp_t        e;
        logic [25:0] exp_bus[$];
        logic        was_dead;
        int          n;
        int          lat;
        was_dead = dead_m;
        bus_log.delete();
        maroon_cnt = 0;
        push_expected(op, l, r);
        req_valid = 1'b1;
        req_op    = op;
        req_left  = l;
        req_right = r;
        rsp_ready = (stall == 0);
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL req_accept_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 4'hF;
        req_left  = 16'hDEAD;
        req_right = 16'hBEEF;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        if (e.exp && !was_dead) dead_m = 1'b1;
        checks++;
        if (lat !== e.lat) begin
            errors++;
            $display("FAIL latency op=%h: got %0d cycles, required %0d", op, lat, e.lat);
        end
        checks++;
        if (rsp_data !== e.data) begin
            errors++;
            $display("FAIL rsp_data op=%h: got %h, required %h", op, rsp_data, e.data);
        end
        checks++;
        if (rsp_err !== e.err || rsp_exp !== e.exp) begin
            errors++;
            $display("FAIL rsp_flags op=%h: got err=%b exp=%b, required err=%b exp=%b",
                     op, rsp_err, rsp_exp, e.err, e.exp);
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_data !== e.data ||
                rsp_err !== e.err || rsp_exp !== e.exp) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got valid=%b ready=%b data=%h, required valid=1 ready=0 data=%h",
                         i, rsp_valid, req_ready, rsp_data, e.data);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsp_release: rsp_valid=%b after handshake, required 0", rsp_valid);
        end
        if (!was_dead) begin
            exp_bus.push_back({1'b0, 7'h10, l, 2'b11});
            exp_bus.push_back({1'b0, 7'h14, r, 2'b11});
            exp_bus.push_back({1'b0, 7'h08, 1'b1, 11'h000, op, 2'b11});
            exp_bus.push_back({1'b1, 7'h18, 16'h0000, 2'b00});
            if (e.err) exp_bus.push_back({1'b0, 7'h04, 16'h0100, 2'b10});
        end
        checks++;
        if (bus_log.size() != exp_bus.size()) begin
            errors++;
            $display("FAIL bus_count op=%h: got %0d bus cycles, required %0d", op, bus_log.size(), exp_bus.size());
        end else begin
            foreach (exp_bus[i]) begin
                if (bus_log[i] !== exp_bus[i]) begin
                    errors++;
                    $display("FAIL bus_cycle%0d op=%h: got {rw,addr,wdata,be}=%h, required %h",
                             i, op, bus_log[i], exp_bus[i]);
                end
            end
        end
        checks++;
        if (maroon_cnt != (e.err ? 1 : 0)) begin
            errors++;
            $display("FAIL maroon_pulses op=%h: got %0d, required %0d", op, maroon_cnt, e.err ? 1 : 0);
        end
    endtask

    // Checks the three cycles following a reset release at a negedge.
    task automatic check_init_seq(input string tag);
        @(negedge clk);
        checks++;
        if (gold !== 1'b1 || maroon !== 1'b0 || chip_select !== 1'b0) begin
            errors++;
            $display("FAIL %s_wake: got gold=%b maroon=%b cs=%b, required 1 0 0", tag, gold, maroon, chip_select);
        end
        @(negedge clk);
        checks++;
        if (chip_select !== 1'b1 || rw_ !== 1'b0 || address !== 7'h0C ||
            wdata !== 16'h0300 || byte_en !== 2'b10 || gold !== 1'b0) begin
            errors++;
            $display("FAIL %s_cfg: got cs=%b rw_=%b addr=%h wdata=%h be=%b, required 1 0 0c 0300 10",
                     tag, chip_select, rw_, address, wdata, byte_en);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || chip_select !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready: got req_ready=%b cs=%b, required 1 0", tag, req_ready, chip_select);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (chip_select !== 1'b0 || rw_ !== 1'b1 || address !== 7'h00 || byte_en !== 2'b00 ||
            wdata !== 16'h0000 || maroon !== 1'b0 || gold !== 1'b0 || req_ready !== 1'b0 ||
            rsp_valid !== 1'b0 || rsp_data !== 16'h0000 || rsp_err !== 1'b0 || rsp_exp !== 1'b0) begin
            errors++;
            $display("FAIL %s: got cs=%b rw_=%b addr=%h be=%b wdata=%h maroon=%b gold=%b rdy=%b vld=%b data=%h err=%b exp=%b, required all idle/zero",
                     tag, chip_select, rw_, address, byte_en, wdata, maroon, gold, req_ready,
                     rsp_valid, rsp_data, rsp_err, rsp_exp);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_b = 1'b0;
        #1;
        check_reset_outputs("reset_hold");
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_hold_clocked");
        rst_b = 1'b1;
        check_init_seq("reset");
    endtask

    task automatic test_add();
        do_op(4'h1, 16'h0003, 16'h0004, 0);
        do_op(4'h2, 16'h1234, 16'h0034, 0);
        do_op(4'h3, 16'h00F0, 16'h0FF0, 0);
    endtask

    task automatic test_overflow();
        do_op(4'h1, 16'h7FFF, 16'h0001, 0);
        do_op(4'h2, 16'h8000, 16'h0001, 0);
        do_op(4'h9, 16'h0001, 16'h0002, 0);
    endtask

    task automatic test_back_to_back();
        do_op(4'h1, 16'h0100, 16'h0200, 0);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back_ready: got req_ready=%b right after handshake, required 1", req_ready);
        end
        do_op(4'h2, 16'h0010, 16'h0020, 0);
        do_op(4'h1, 16'hFFFF, 16'h0001, 0);
    endtask

    task automatic test_stall();
        do_op(4'h1, 16'h0A0A, 16'h0505, 3);
    endtask

    task automatic test_reset_mid();
        int n;
        int stray;
        req_valid = 1'b1;
        req_op    = 4'h1;
        req_left  = 16'h0011;
        req_right = 16'h0022;
        n = 0;
        while (!(chip_select === 1'b1 && rw_ === 1'b0 && address === 7'h08) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL reset_mid_wr_cmd: WR_CMD not reached after %0d cycles, required within 20", n);
        end
        #1 rst_b = 1'b0;
        req_valid = 1'b0;
        #1;
        check_reset_outputs("reset_mid_now");
        @(negedge clk);
        rst_b = 1'b1;
        check_init_seq("reset_mid");
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL reset_mid_no_rsp: got %0d cycles of rsp_valid, required 0", stray);
        end
    endtask

    task automatic test_export();
        export_disabled = 1'b1;
        do_op(4'h3, 16'h0005, 16'h0006, 0);
        do_op(4'h1, 16'h0001, 16'h0001, 0);
        do_op(4'h2, 16'h0009, 16'h0003, 2);
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_export();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vchip_op_sequencer.md
VCHIP_OP_SEQUENCER -- requirements
Module: vchip_op_sequencer

Interface
REQ-001 SHALL have parameter: WAIT_CYC, default 1, idle bus cycles between command write and result read (legal 1..7).
REQ-002 SHALL have ports, one per line:
- clk  in  1  clock
- rst_b  in  1  reset, asynchronous, active-low
- req_valid  in  1  operation request valid
- req_ready  out  1  request accepted when high with req_valid at posedge
- req_op  in  4  ALU command code
- req_left  in  16  left operand
- req_right  in  16  right operand
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when high with rsp_valid at posedge
- rsp_data  out  16  ALU result read back
- rsp_err  out  1  chip flagged overflow/bad command
- rsp_exp  out  1  chip entered export-locked state
- chip_select  out  1  chip bus select
- address  out  7  chip register address
- byte_en  out  2  write byte enables
- rw_  out  1  1=read, 0=write
- wdata  out  16  chip write data
- rdata  in  16  chip read data, combinational same cycle
- interrupt_1  in  1  chip error interrupt
- interrupt_2  in  1  chip export interrupt
- maroon  out  1  chip state-machine input
- gold  out  1  chip state-machine input

Function
REQ-003 SHALL implement a state machine: INIT_WAKE, INIT_CFG, IDLE, WR_LEFT, WR_RIGHT, WR_CMD, WAIT, READ, RECOVER, CLR_INT, RESP, DEAD.
REQ-004 SHALL decode all bus, maroon and gold outputs from current state only.
REQ-005 SHALL drive idle defaults when not stated otherwise: chip_select=0, rw_=1, address=0, byte_en=0, wdata=0, maroon=0, gold=0.
REQ-006 INIT_WAKE SHALL last 1 cycle, drive gold=1 and maroon=0, then go to INIT_CFG.
REQ-007 INIT_CFG SHALL write address 0x0C, wdata 0x0300, byte_en 2'b10 for 1 cycle, then go to IDLE.
REQ-008 SHALL assert req_ready only in IDLE, and in DEAD when rsp_valid=0.
REQ-009 On acceptance, SHALL capture req_op, req_left and req_right; later changes to req_* SHALL have no effect.
REQ-010 Each write state SHALL last 1 cycle with chip_select=1, rw_=0, byte_en=2'b11, in this order:
- WR_LEFT: address 0x10, wdata=left
- WR_RIGHT: address 0x14, wdata=right
- WR_CMD: address 0x08, wdata={1'b1, 11'h0, op}
REQ-011 WAIT SHALL last WAIT_CYC cycles with the bus idle.
REQ-012 READ SHALL last 1 cycle with chip_select=1, rw_=1, address 0x18.
REQ-013 In READ, SHALL capture rdata into rsp_data and sample interrupt_2, then interrupt_1, with interrupt_2 taking priority.
REQ-014 READ transitions SHALL be:
- interrupt_2=1: set rsp_exp=1, rsp_err=0, go to RESP, and set the sticky dead flag
- else interrupt_1=1: set rsp_err=1, go to RECOVER
- else: go to RESP
REQ-015 RECOVER SHALL drive maroon=1 and gold=0 for 1 cycle, then go to CLR_INT.
REQ-016 CLR_INT SHALL write address 0x04, wdata 0x0100, byte_en 2'b10 for 1 cycle, then go to RESP.
REQ-017 RESP SHALL assert rsp_valid and hold rsp_data, rsp_err and rsp_exp stable until rsp_ready=1.
REQ-018 On leaving RESP, SHALL clear rsp_valid and go to DEAD if the dead flag is set, else to IDLE.
REQ-019 Latency from acceptance edge to rsp_valid high SHALL be 5+WAIT_CYC cycles on success and 7+WAIT_CYC cycles on error.
REQ-020 A request accepted in DEAD SHALL cause no bus traffic and go to RESP next cycle with rsp_data=0, rsp_exp=1, rsp_err=0.
REQ-021 rsp_ready asserted while rsp_valid=0 SHALL be ignored.
REQ-022 Back-to-back operation: a request SHALL be acceptable in the cycle after the RESP handshake.

Reset
REQ-023 rst_b low SHALL asynchronously force:
- state INIT_WAKE, dead flag 0
- rsp_valid=0, rsp_data=0, rsp_err=0, rsp_exp=0, req_ready=0
- bus, maroon and gold to idle defaults
REQ-024 Reset mid-operation SHALL discard the in-flight request with no response, and re-run INIT_WAKE/INIT_CFG after release.

Verification
REQ-025 Reset release -> cycle 1 gold=1, maroon=0; cycle 2 write 0x0C/0x0300/be 2'b10; cycle 3 req_ready=1.
REQ-026 ADD op 0x1, 0x0003+0x0004, WAIT_CYC=1 -> writes 0x10=0x0003, 0x14=0x0004, 0x08=0x8001; read 0x18; rsp_data=0x0007, rsp_err=0, rsp_valid at acceptance+6.
REQ-027 ADD 0x7FFF+0x0001 -> interrupt_1 -> rsp_data=0x8000, rsp_err=1; one cycle maroon=1/gold=0; write 0x04/0x0100/be 2'b10; rsp_valid at acceptance+8.
REQ-028 Export-disabled chip, op 0x3 -> interrupt_2 -> rsp_exp=1, rsp_data=0x0000; next request answered with rsp_exp=1 after 1 cycle, chip_select never asserted.
REQ-029 rsp_ready held 0 for 3 cycles during RESP -> rsp_* stable, req_ready=0, accepted on 4th cycle.
REQ-030 rst_b pulsed low during WR_CMD -> outputs immediately at reset values, no response, init sequence repeats.
